// File: rtl/nand4_sweep_ctrl.sv
// nand4_sweep_ctrl
// Runs all 16 input vectors through a 4-input NAND gate and checks each result.
// For every vector it holds the value for SETTLE_CYCLES cycles, then spends one
// CHECK cycle sampling the gate output and comparing it with ~&vec.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for start; results of the last sweep are held
//   SETTLE | current vector driven, settle counter running down
//   CHECK  | one cycle; dut_e is sampled on the edge that ends it
//   DONE   | one cycle; done pulses and pass is computed
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start            request a sweep (honoured only in IDLE)
//   dut_e            output of the gate under test
//   a, b, c, d       gate inputs, {a,b,c,d} = vec
//   busy             high during SETTLE and CHECK
//   done             one-cycle pulse after the last CHECK
//   pass             last completed sweep had no mismatches
//   err_count        mismatch count, 0..16
//   first_fail       first mismatching vector
//   fail_valid       first_fail holds a captured vector
module nand4_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_e,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail,
  output logic       fail_valid
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  // The counter counts from S-1 down to 0, so SETTLE lasts exactly S cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] vec;
  logic [3:0] settle_cnt;
  logic       mismatch;

  assign {a, b, c, d} = vec;
  assign mismatch     = (dut_e != ~&vec);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= 4'd0;
      settle_cnt <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 5'd0;
      first_fail <= 4'd0;
      fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec        <= 4'd0;
            err_count  <= 5'd0;
            first_fail <= 4'd0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) state <= CHECK;
          else settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          // At most 16 mismatches can occur in one sweep, so 5 bits never wrap.
          if (mismatch) begin
            err_count <= err_count + 5'd1;
            if (!fail_valid) begin
              first_fail <= vec;
              fail_valid <= 1'b1;
            end
          end
          if (vec == 4'hF) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            vec        <= vec + 4'd1;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        DONE: begin
          // err_count already includes any mismatch from the final CHECK.
          pass  <= (err_count == 5'd0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand4_sweep_ctrl.sv
// Testbench for nand4_sweep_ctrl: three instances with S=2 (fault modes selectable),
// S=1 and S=15 (golden gate model).
module tb_nand4_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s [3];
  logic       e_s     [3];
  logic       a_s     [3];
  logic       b_s     [3];
  logic       c_s     [3];
  logic       d_s     [3];
  logic       busy_s  [3];
  logic       done_s  [3];
  logic       pass_s  [3];
  logic [4:0] err_s   [3];
  logic [3:0] ff_s    [3];
  logic       fv_s    [3];

  int mode = 0;  // 0 golden NAND, 1 stuck at 1, 2 stuck at 0, 3 AND gate
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    e_s[0] = ~&{a_s[0], b_s[0], c_s[0], d_s[0]};
    case (mode)
      1: e_s[0] = 1'b1;
      2: e_s[0] = 1'b0;
      3: e_s[0] = &{a_s[0], b_s[0], c_s[0], d_s[0]};
      default: ;
    endcase
  end
  assign e_s[1] = ~&{a_s[1], b_s[1], c_s[1], d_s[1]};
  assign e_s[2] = ~&{a_s[2], b_s[2], c_s[2], d_s[2]};

  nand4_sweep_ctrl #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .rst(rst), .start(start_s[0]), .dut_e(e_s[0]),
    .a(a_s[0]), .b(b_s[0]), .c(c_s[0]), .d(d_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .err_count(err_s[0]), .first_fail(ff_s[0]), .fail_valid(fv_s[0]));

  nand4_sweep_ctrl #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .dut_e(e_s[1]),
    .a(a_s[1]), .b(b_s[1]), .c(c_s[1]), .d(d_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .err_count(err_s[1]), .first_fail(ff_s[1]), .fail_valid(fv_s[1]));

  nand4_sweep_ctrl #(.SETTLE_CYCLES(15)) u_s15 (
    .clk(clk), .rst(rst), .start(start_s[2]), .dut_e(e_s[2]),
    .a(a_s[2]), .b(b_s[2]), .c(c_s[2]), .d(d_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
    .err_count(err_s[2]), .first_fail(ff_s[2]), .fail_valid(fv_s[2]));

  typedef struct {
    string name;
    int    mode;
    int    inject;
    int    exp_err;
    int    exp_first;
    int    exp_fv;
    int    exp_pass;
  } vec_t;

  vec_t tbl [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] vec_of(input int idx);
    return {a_s[idx], b_s[idx], c_s[idx], d_s[idx]};
  endfunction

  task automatic check_reset_vals(input int idx, input string tag);
    check({tag, " vec"},        int'(vec_of(idx)), 0);
    check({tag, " busy"},       int'(busy_s[idx]), 0);
    check({tag, " done"},       int'(done_s[idx]), 0);
    check({tag, " pass"},       int'(pass_s[idx]), 0);
    check({tag, " err_count"},  int'(err_s[idx]),  0);
    check({tag, " first_fail"}, int'(ff_s[idx]),   0);
    check({tag, " fail_valid"}, int'(fv_s[idx]),   0);
  endtask

  // Start a sweep on instance idx and watch it cycle by cycle. k counts samples
  // taken 1 time unit after each edge, with k=0 right after the start edge E0.
  task automatic run_sweep(input int idx, input int s, input int inject,
                           input int exp_err, input int exp_first,
                           input int exp_fv, input int exp_pass, input string tag);
    int n = 16 * (s + 1);
    int seq_bad = 0;
    int done_cnt = 0;
    int done_at = -1;
    logic [3:0] v;
    start_s[idx] = 1'b1;
    tick();
    start_s[idx] = 1'b0;
    for (int k = 0; k <= n + 4; k++) begin
      if (k > 0) begin
        tick();
        start_s[idx] = 1'b0;
      end
      v = vec_of(idx);
      if (done_s[idx]) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k < n) begin
        if (v != 4'(k / (s + 1)) || !busy_s[idx] || done_s[idx]) seq_bad++;
      end else begin
        if (v != 4'hF || busy_s[idx]) seq_bad++;
      end
      if (k == inject) start_s[idx] = 1'b1;
    end
    check({tag, " sequence errors"}, seq_bad, 0);
    check({tag, " done cycle"}, done_at, n);
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " err_count"}, int'(err_s[idx]), exp_err);
    check({tag, " first_fail"}, int'(ff_s[idx]), exp_first);
    check({tag, " fail_valid"}, int'(fv_s[idx]), exp_fv);
    check({tag, " pass"}, int'(pass_s[idx]), exp_pass);
  endtask

  initial begin
    int waited;
    tbl[0] = '{"golden",      0, -1,  0,  0, 0, 1};
    tbl[1] = '{"stuck1",      1, -1,  1, 15, 1, 0};
    tbl[2] = '{"stuck0",      2, -1, 15,  0, 1, 0};
    tbl[3] = '{"and_gate",    3, -1, 16,  0, 1, 0};
    tbl[4] = '{"start_again", 0, 10,  0,  0, 0, 1};

    for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_vals(0, "por s2");
    check_reset_vals(1, "por s1");
    check_reset_vals(2, "por s15");

    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      run_sweep(0, 2, tbl[i].inject, tbl[i].exp_err, tbl[i].exp_first,
                tbl[i].exp_fv, tbl[i].exp_pass, tbl[i].name);
    end

    // Reset mid-sweep with mismatches already recorded.
    mode = 2;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    waited = 0;
    while (vec_of(0) != 4'd7 && waited < 200) begin
      tick();
      waited++;
    end
    check("reach vec 7", int'(vec_of(0)), 7);
    check("errors before reset", int'(err_s[0]), 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals(0, "mid rst");
    tick();
    tick();
    check("idle after rst vec", int'(vec_of(0)), 0);
    check("idle after rst busy", int'(busy_s[0]), 0);
    mode = 0;
    run_sweep(0, 2, -1, 0, 0, 0, 1, "post_rst golden");

    run_sweep(1, 1, -1, 0, 0, 0, 1, "s1 golden");
    run_sweep(2, 15, -1, 0, 0, 0, 1, "s15 golden");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
